// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver.
// Captures 4-bit nibbles into a shift register of N_DIGITS digits. A free-running
// prescaler and scan index select one digit at a time, and a registered output stage
// drives a one-hot strobe plus the decoded segments {a,b,c,d,e,f,g}. All outputs are
// active-high.
// Optional feature macro: SSD_LEADING_ZERO_BLANK_EN blanks leading zeros on digits 1 and up.
// Digit 0 is always shown.

module ssd_scan_driver #(
   parameter int unsigned N_DIGITS    = 4,
   parameter int unsigned REFRESH_DIV = 1000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                clear,
   input  logic                in_valid,
   input  logic [3:0]          in_nibble,
   output logic [N_DIGITS-1:0] an,
   output logic [6:0]          seg
);

   localparam int unsigned PreW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [PreW-1:0] PreLast = PreW'(REFRESH_DIV - 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(N_DIGITS - 1);

   // Hex to {a,b,c,d,e,f,g}, active-high
   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'h7E;
         4'h1:    s = 7'h30;
         4'h2:    s = 7'h6D;
         4'h3:    s = 7'h79;
         4'h4:    s = 7'h33;
         4'h5:    s = 7'h5B;
         4'h6:    s = 7'h5F;
         4'h7:    s = 7'h70;
         4'h8:    s = 7'h7F;
         4'h9:    s = 7'h7B;
         4'hA:    s = 7'h77;
         4'hB:    s = 7'h1F;
         4'hC:    s = 7'h4E;
         4'hD:    s = 7'h3D;
         4'hE:    s = 7'h4F;
         default: s = 7'h47;
      endcase
      return s;
   endfunction

   logic [N_DIGITS-1:0][3:0] digit_q, digit_d;
   logic [PreW-1:0]          pre_q, pre_d;
   logic [IdxW-1:0]          idx_q, idx_d;
   logic [N_DIGITS-1:0]      an_q, an_d;
   logic [6:0]               seg_q, seg_d;
   logic                     scan_tick;
   logic [3:0]               sel_digit;
   logic                     sel_blank;
   logic [N_DIGITS-1:0]      blank_vec;

   // Digit store next state: clear beats capture, capture shifts toward the left
   always_comb begin
      digit_d = digit_q;
      if (clear) begin
         digit_d = '0;
      end else if (in_valid) begin
         digit_d = {digit_q[N_DIGITS-2:0], in_nibble};
      end
   end

   // Prescaler and scan index run regardless of enable so the scan phase is never disturbed
   always_comb begin
      scan_tick = (pre_q == PreLast);
      pre_d     = scan_tick ? '0 : pre_q + PreW'(1);
      idx_d     = idx_q;
      if (scan_tick) begin
         idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
      end
   end

`ifdef SSD_LEADING_ZERO_BLANK_EN
   // Blank digit i (i >= 1) when it and every digit above it are zero
   always_comb begin
      logic zero_above;
      zero_above = 1'b1;
      blank_vec  = '0;
      for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
         zero_above   = zero_above & (digit_q[i] == 4'h0);
         blank_vec[i] = zero_above & (i != 0);
      end
   end
`else
   // Every digit is decoded, leading zeros included
   always_comb begin
      blank_vec = '0;
   end
`endif

   // Mux the currently indexed digit and its blanking flag
   always_comb begin
      sel_digit = 4'h0;
      sel_blank = 1'b0;
      for (int i = 0; i < int'(N_DIGITS); i++) begin
         if (idx_q == IdxW'(i)) begin
            sel_digit = digit_q[i];
            sel_blank = blank_vec[i];
         end
      end
   end

   // Output stage next state: one-hot strobe and decoded segments, forced dark when disabled
   always_comb begin
      an_d  = '0;
      seg_d = '0;
      if (enable) begin
         an_d = N_DIGITS'(1) << idx_q;
         if (!sel_blank) begin
            seg_d = decode(sel_digit);
         end
      end
   end

   // All state, asynchronously cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_q <= '0;
         pre_q   <= '0;
         idx_q   <= '0;
         an_q    <= '0;
         seg_q   <= '0;
      end else begin
         digit_q <= digit_d;
         pre_q   <= pre_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver (N_DIGITS=4, REFRESH_DIV=4).
// The reference model derives the strobed digit from the number of edges since
// reset release, and keeps the digit store as a plain array.

module tb_ssd_scan_driver;

   localparam int unsigned N  = 4;
   localparam int unsigned RD = 4;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         enable    = 1'b0;
   logic         clear     = 1'b0;
   logic         in_valid  = 1'b0;
   logic [3:0]   in_nibble = 4'h0;
   logic [N-1:0] an;
   logic [6:0]   seg;

   ssd_scan_driver #(
      .N_DIGITS   (N),
      .REFRESH_DIV(RD)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .clear    (clear),
      .in_valid (in_valid),
      .in_nibble(in_nibble),
      .an       (an),
      .seg      (seg)
   );

   always #5 clk = ~clk;

   int          err_cnt = 0;
   int          chk_cnt = 0;
   int unsigned k;
   logic [3:0]  m_dig [N];
   logic [6:0]  seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [6:0] shown(input int idx);
      int hi;
      hi = -1;
      for (int i = 0; i < int'(N); i++) if (m_dig[i] != 4'h0) hi = i;
`ifdef SSD_LEADING_ZERO_BLANK_EN
      if (idx >= 1 && idx > hi) return 7'h00;
`endif
      return seg_tab[m_dig[idx]];
   endfunction

   task automatic model_reset();
      k = 0;
      for (int i = 0; i < int'(N); i++) m_dig[i] = 4'h0;
   endtask

   // Called at posedge+1; drives inputs, takes one edge, checks the outputs
   task automatic step(input logic en, input logic clr, input logic vld, input logic [3:0] nib);
      int           idx;
      logic [N-1:0] e_an;
      logic [6:0]   e_seg;
      enable    = en;
      clear     = clr;
      in_valid  = vld;
      in_nibble = nib;
      @(posedge clk);
      idx   = int'((k / RD) % N);
      e_an  = '0;
      e_seg = 7'h00;
      if (en) begin
         e_an[idx] = 1'b1;
         e_seg     = shown(idx);
      end
      if (clr) begin
         for (int i = 0; i < int'(N); i++) m_dig[i] = 4'h0;
      end else if (vld) begin
         for (int i = int'(N) - 1; i >= 1; i--) m_dig[i] = m_dig[i-1];
         m_dig[0] = nib;
      end
      k++;
      #1;
      check("an", 32'(an), 32'(e_an));
      check("seg", 32'(seg), 32'(e_seg));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 4'h0);
   endtask

   task automatic load(input logic [3:0] nib);
      step(1'b1, 1'b0, 1'b1, nib);
   endtask

   initial begin
      model_reset();
      // Reset held
      #12;
      check("reset_an", 32'(an), 32'h0);
      check("reset_seg", 32'(seg), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();

      // First strobe and stepping
      idle(20);

      // Capture and shift, then a fifth nibble
      load(4'h1);
      load(4'h2);
      load(4'h3);
      load(4'h4);
      idle(16);
      load(4'hF);
      idle(16);

      // Clear beats capture
      step(1'b1, 1'b1, 1'b1, 4'h8);
      idle(16);

      // Enable dropped mid-frame
      load(4'h9);
      idle(5);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 4'h0);
      idle(16);

      // Leading-zero patterns
      step(1'b1, 1'b1, 1'b0, 4'h0);
      load(4'h0);
      load(4'h0);
      load(4'h0);
      load(4'h5);
      idle(16);
      load(4'h0);
      load(4'h7);
      load(4'h0);
      load(4'h0);
      idle(16);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)));
      end

      // Asynchronous reset mid-frame with a populated store
      load(4'hA);
      load(4'h3);
      idle(5);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_an", 32'(an), 32'h0);
      check("async_seg", 32'(seg), 32'h0);
      @(posedge clk);
      #1;
      check("held_an", 32'(an), 32'h0);
      rst_n = 1'b1;
      model_reset();
      idle(20);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
